// File: rtl/robo_nav_pkg.sv
// Shared types for the wall-following navigation core: FSM state encoding,
// wall-side selection constants and the turn-decision helper.
package robo_nav_pkg;

    localparam int unsigned STATE_W    = 3;
    localparam int unsigned LEFT_HAND  = 0;
    localparam int unsigned RIGHT_HAND = 1;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 3'd0,
        ST_FWD    = 3'd1,
        ST_TURN_L = 3'd2,
        ST_TURN_R = 3'd3,
        ST_UTURN  = 3'd4,
        ST_COMMIT = 3'd5
    } nav_state_e;

    // Wall-follow priority: followed side, then straight, then far side, then U-turn.
    function automatic nav_state_e decide(input logic right_hand, input logic wall_f,
                                          input logic wall_l, input logic wall_r);
        logic near_wall;
        logic far_wall;
        near_wall = right_hand ? wall_r : wall_l;
        far_wall  = right_hand ? wall_l : wall_r;
        if (!near_wall)     return right_hand ? ST_TURN_R : ST_TURN_L;
        else if (!wall_f)   return ST_FWD;
        else if (!far_wall) return right_hand ? ST_TURN_L : ST_TURN_R;
        else                return ST_UTURN;
    endfunction

endpackage

// File: rtl/robo_debounce.sv
// Single-sensor tick-sampled debounce: the filtered value flips after DEB
// consecutive ticks of disagreement with the raw input.
module robo_debounce
    import robo_nav_pkg::*;
#(
    parameter int unsigned DEB = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic raw,
    output logic filt
);

    localparam int unsigned RUN_W = (DEB > 1) ? $clog2(DEB + 1) : 1;

    logic [RUN_W-1:0] run_q, run_d;
    logic             filt_q, filt_d;

    always_comb begin
        run_d  = run_q;
        filt_d = filt_q;
        if (tick) begin
            if (raw != filt_q) begin
                if (run_q == RUN_W'(DEB - 1)) begin
                    filt_d = ~filt_q;
                    run_d  = '0;
                end else begin
                    run_d = run_q + RUN_W'(1);
                end
            end else begin
                run_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            run_q  <= '0;
            filt_q <= 1'b0;
        end else begin
            run_q  <= run_d;
            filt_q <= filt_d;
        end
    end

    assign filt = filt_q;

endmodule

// File: rtl/robo_nav.sv
// Wall-following navigation core: tick divider, three sensor debouncers and a
// Moore FSM issuing forward/turn commands. Define ROBO_NAV_OUT_INV_EN for
// active-low motor outputs.
module robo_nav
    import robo_nav_pkg::*;
#(
    parameter int unsigned DIV        = 25_000_000,
    parameter int unsigned DEB        = 3,
    parameter int unsigned TURN_TICKS = 2,
    parameter int unsigned WALL_SIDE  = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       front,
    input  logic       left,
    input  logic       right,
    output logic       forward,
    output logic       turn_left,
    output logic       turn_right,
    output logic [2:0] state
);

    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned TC_W  = $clog2(2 * TURN_TICKS);
    localparam logic        RH    = (WALL_SIDE == RIGHT_HAND);

`ifdef ROBO_NAV_OUT_INV_EN
    localparam logic OUT_INV = 1'b1;
`else
    localparam logic OUT_INV = 1'b0;
`endif

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_c;
    logic             filt_f, filt_l, filt_r;

    nav_state_e       state_q, state_d;
    logic [TC_W-1:0]  turn_cnt_q, turn_cnt_d;
    logic [TC_W-1:0]  turn_last_c;
    logic             fwd_d, tl_d, tr_d;
    logic             fwd_q, tl_q, tr_q;

    // Free-running decision tick divider.
    assign tick_c = (cnt_q == CNT_W'(DIV - 1));
    assign cnt_d  = tick_c ? '0 : cnt_q + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    robo_debounce #(.DEB(DEB)) u_deb_front (
        .clk (clk), .rst (rst), .tick (tick_c), .raw (front), .filt (filt_f)
    );
    robo_debounce #(.DEB(DEB)) u_deb_left (
        .clk (clk), .rst (rst), .tick (tick_c), .raw (left), .filt (filt_l)
    );
    robo_debounce #(.DEB(DEB)) u_deb_right (
        .clk (clk), .rst (rst), .tick (tick_c), .raw (right), .filt (filt_r)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            turn_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            turn_cnt_q <= turn_cnt_d;
        end
    end

    assign turn_last_c = (state_q == ST_UTURN) ? TC_W'(2 * TURN_TICKS - 1)
                                               : TC_W'(TURN_TICKS - 1);

    // Next-state logic; filters are read before their own tick update lands.
    always_comb begin
        state_d    = state_q;
        turn_cnt_d = turn_cnt_q;
        if (!en) begin
            state_d    = ST_IDLE;
            turn_cnt_d = '0;
        end else if (tick_c) begin
            case (state_q)
                ST_IDLE, ST_FWD, ST_COMMIT: begin
                    state_d    = decide(RH, filt_f, filt_l, filt_r);
                    turn_cnt_d = '0;
                end
                ST_TURN_L, ST_TURN_R, ST_UTURN: begin
                    if (turn_cnt_q == turn_last_c) begin
                        state_d    = ST_COMMIT;
                        turn_cnt_d = '0;
                    end else begin
                        turn_cnt_d = turn_cnt_q + TC_W'(1);
                    end
                end
                default: begin
                    state_d    = ST_IDLE;
                    turn_cnt_d = '0;
                end
            endcase
        end
    end

    // Output decode from the next state so registered outputs track state_q.
    always_comb begin
        fwd_d = (state_d == ST_FWD) || (state_d == ST_COMMIT);
        tl_d  = (state_d == ST_TURN_L) || ((state_d == ST_UTURN) && RH);
        tr_d  = (state_d == ST_TURN_R) || ((state_d == ST_UTURN) && !RH);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fwd_q <= OUT_INV;
            tl_q  <= OUT_INV;
            tr_q  <= OUT_INV;
        end else begin
            fwd_q <= fwd_d ^ OUT_INV;
            tl_q  <= tl_d ^ OUT_INV;
            tr_q  <= tr_d ^ OUT_INV;
        end
    end

    assign forward    = fwd_q;
    assign turn_left  = tl_q;
    assign turn_right = tr_q;
    assign state      = state_q;

endmodule

// File: tb/tb_robo_nav.sv
// Directed bench for robo_nav: left-hand and right-hand instances driven by the
// same sensors, DIV=4, DEB=2, TURN_TICKS=2.
module tb_robo_nav;

    localparam int DIV = 4;

`ifdef ROBO_NAV_OUT_INV_EN
    localparam logic INV = 1'b1;
`else
    localparam logic INV = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst, en, front, left, right;
    logic       fwd_l, tl_l, tr_l, fwd_r, tl_r, tr_r;
    logic [2:0] st_l, st_r;

    int n_checks = 0;
    int n_fail   = 0;
    int phase    = 0;

    always #5 clk = ~clk;

    robo_nav #(.DIV(4), .DEB(2), .TURN_TICKS(2), .WALL_SIDE(0)) dut_l (
        .clk(clk), .rst(rst), .en(en), .front(front), .left(left), .right(right),
        .forward(fwd_l), .turn_left(tl_l), .turn_right(tr_l), .state(st_l)
    );

    robo_nav #(.DIV(4), .DEB(2), .TURN_TICKS(2), .WALL_SIDE(1)) dut_r (
        .clk(clk), .rst(rst), .en(en), .front(front), .left(left), .right(right),
        .forward(fwd_r), .turn_left(tl_r), .turn_right(tr_r), .state(st_r)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // {forward, turn_left, turn_right} each state must produce.
    function automatic logic [2:0] exp_out(input int st, input bit rh);
        logic [2:0] o;
        case (st)
            1, 5:    o = 3'b100;
            2:       o = 3'b010;
            3:       o = 3'b001;
            4:       o = rh ? 3'b010 : 3'b001;
            default: o = 3'b000;
        endcase
        return o ^ {3{INV}};
    endfunction

    task automatic chk_nav(input string tag, input int sl, input int sr);
        check({tag, "/st_l"},  32'(st_l), 32'(sl));
        check({tag, "/out_l"}, 32'({fwd_l, tl_l, tr_l}), 32'(exp_out(sl, 1'b0)));
        check({tag, "/st_r"},  32'(st_r), 32'(sr));
        check({tag, "/out_r"}, 32'({fwd_r, tl_r, tr_r}), 32'(exp_out(sr, 1'b1)));
    endtask

    task automatic edge_step();
        @(posedge clk);
        #1;
        phase = (phase + 1) % DIV;
    endtask

    // Advance through the next tick edge.
    task automatic tick_step();
        bit was_tick;
        for (int i = 0; i < DIV; i++) begin
            was_tick = (phase == DIV - 1);
            edge_step();
            if (was_tick) break;
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; front = 1'b0; left = 1'b0; right = 1'b0;

        // Reset with random sensors.
        repeat (3) begin
            {front, left, right} = 3'($urandom_range(0, 7));
            @(posedge clk);
            #1;
            chk_nav("rst", 0, 0);
        end
        rst = 1'b0; phase = 0;
        front = 1'b0; left = 1'b1; right = 1'b1;
        repeat (3) begin
            edge_step();
            chk_nav("pre_tick", 0, 0);
        end
        edge_step();
        chk_nav("first_tick", 2, 3);

        en = 1'b0;
        edge_step();
        chk_nav("en_abort", 0, 0);
        repeat (3) tick_step();

        // Corridor: walls left and right.
        en = 1'b1;
        repeat (3) begin
            edge_step();
            chk_nav("idle_wait", 0, 0);
        end
        edge_step();
        chk_nav("fwd", 1, 1);
        repeat (2) begin
            tick_step();
            chk_nav("fwd_hold", 1, 1);
        end

        // Left opening.
        left = 1'b0;
        tick_step(); chk_nav("open_t1", 1, 1);
        tick_step(); chk_nav("open_t2", 1, 1);
        tick_step(); chk_nav("turn_l", 2, 1);
        left = 1'b1;
        for (int i = 1; i < 8; i++) begin
            edge_step();
            chk_nav("turn_l_hold", 2, 1);
        end
        for (int i = 0; i < 4; i++) begin
            edge_step();
            chk_nav("commit", 5, 1);
        end
        edge_step();
        chk_nav("redecide", 1, 1);

        // One-tick glitch on left must not turn.
        left = 1'b0;
        tick_step(); chk_nav("glitch", 1, 1);
        left = 1'b1;
        repeat (3) begin
            tick_step();
            chk_nav("glitch_hold", 1, 1);
        end

        // Dead end.
        front = 1'b1;
        tick_step(); chk_nav("dead_t1", 1, 1);
        tick_step(); chk_nav("dead_t2", 1, 1);
        tick_step(); chk_nav("uturn", 4, 4);
        for (int i = 1; i < 16; i++) begin
            edge_step();
            chk_nav("uturn_hold", 4, 4);
        end
        for (int i = 0; i < 4; i++) begin
            edge_step();
            chk_nav("u_commit", 5, 5);
        end
        edge_step();
        chk_nav("uturn2", 4, 4);
        repeat (4) edge_step();
        chk_nav("uturn2_hold", 4, 4);
        en = 1'b0;
        edge_step();
        chk_nav("en_drop", 0, 0);

        // Right-only opening, then reset mid-turn.
        right = 1'b0;
        repeat (3) tick_step();
        en = 1'b1;
        tick_step(); chk_nav("turn_r", 3, 3);
        edge_step(); chk_nav("turn_r_hold", 3, 3);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk_nav("rst_mid", 0, 0);
        rst = 1'b0; phase = 0;
        repeat (3) begin
            edge_step();
            chk_nav("post_rst", 0, 0);
        end
        edge_step();
        chk_nav("filt_reset", 2, 3);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
